// File: rtl/jtag_tap_param.sv
// Parametrised IEEE 1149.1 TAP controller.
// Owns the boundary-scan cells, a 32-bit IDCODE register, a 1-bit bypass
// register and a user data register. The user register's update latch and
// the debug state are exposed to core logic. TDO is launched on the falling
// edge of tclk.
module jtag_tap_param #(
    parameter int unsigned IR_W    = 4,
    parameter logic [31:0] IDCODE  = 32'h1000_563F,
    parameter int unsigned BSR_LEN = 8,
    parameter int unsigned USER_W  = 8
) (
    input  logic                tclk,
    input  logic                trst,
    input  logic                tms,
    input  logic                tdi,
    output logic                tdo,
    output logic                tdo_en,
    input  logic [BSR_LEN-1:0]  pin_in,
    output logic [BSR_LEN-1:0]  pin_out,
    output logic                extest,
    output logic [USER_W-1:0]   user_dr,
    output logic                user_update,
    output logic [3:0]          state,
    output logic [IR_W-1:0]     ir
);

    // TAP state encoding (debug-visible)
    localparam logic [3:0] S_TLR      = 4'd0;
    localparam logic [3:0] S_RTI      = 4'd1;
    localparam logic [3:0] S_SEL_DR   = 4'd2;
    localparam logic [3:0] S_CAP_DR   = 4'd3;
    localparam logic [3:0] S_SH_DR    = 4'd4;
    localparam logic [3:0] S_EX1_DR   = 4'd5;
    localparam logic [3:0] S_PAUSE_DR = 4'd6;
    localparam logic [3:0] S_EX2_DR   = 4'd7;
    localparam logic [3:0] S_UPD_DR   = 4'd8;
    localparam logic [3:0] S_SEL_IR   = 4'd9;
    localparam logic [3:0] S_CAP_IR   = 4'd10;
    localparam logic [3:0] S_SH_IR    = 4'd11;
    localparam logic [3:0] S_EX1_IR   = 4'd12;
    localparam logic [3:0] S_PAUSE_IR = 4'd13;
    localparam logic [3:0] S_EX2_IR   = 4'd14;
    localparam logic [3:0] S_UPD_IR   = 4'd15;

    // Instruction codes; anything unassigned falls back to bypass
    localparam logic [IR_W-1:0] INS_EXTEST = IR_W'(0);
    localparam logic [IR_W-1:0] INS_IDCODE = IR_W'(1);
    localparam logic [IR_W-1:0] INS_SAMPLE = IR_W'(2);
    localparam logic [IR_W-1:0] INS_USER   = IR_W'(3);
    localparam logic [IR_W-1:0] INS_BYPASS = {IR_W{1'b1}};
    // Capture-IR pattern: ...0001, the two LSBs fixed at 2'b01
    localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(1);

    logic [3:0]         r_state;
    logic [3:0]         w_state_nxt;
    logic [IR_W-1:0]    r_ir;
    logic [IR_W-1:0]    r_ir_sr;
    logic [31:0]        r_id_sr;
    logic [BSR_LEN-1:0] r_bsr_sr;
    logic [USER_W-1:0]  r_user_sr;
    logic               r_byp;
    logic [BSR_LEN-1:0] r_pin_out;
    logic [USER_W-1:0]  r_user_dr;
    logic               r_user_update;
    logic               r_tdo;
    logic               r_tdo_en;

    logic w_cap_dr, w_sh_dr, w_upd_dr, w_cap_ir, w_sh_ir, w_upd_ir;
    logic w_sel_id, w_sel_bsr, w_sel_user;
    logic w_dr_lsb;

    // Shift candidates: tdi enters at the MSB, everything moves one place right
    logic [IR_W:0]    w_ir_shift;
    logic [32:0]      w_id_shift;
    logic [BSR_LEN:0] w_bsr_shift;
    logic [USER_W:0]  w_user_shift;

    assign w_ir_shift   = {tdi, r_ir_sr};
    assign w_id_shift   = {tdi, r_id_sr};
    assign w_bsr_shift  = {tdi, r_bsr_sr};
    assign w_user_shift = {tdi, r_user_sr};

    // TAP state register
    always_ff @(posedge tclk or posedge trst) begin
        if (trst) begin
            r_state <= S_TLR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: the standard TAP graph driven by tms
    always_comb begin
        w_state_nxt = S_TLR;
        case (r_state)
            S_TLR:      w_state_nxt = tms ? S_TLR      : S_RTI;
            S_RTI:      w_state_nxt = tms ? S_SEL_DR   : S_RTI;
            S_SEL_DR:   w_state_nxt = tms ? S_SEL_IR   : S_CAP_DR;
            S_CAP_DR:   w_state_nxt = tms ? S_EX1_DR   : S_SH_DR;
            S_SH_DR:    w_state_nxt = tms ? S_EX1_DR   : S_SH_DR;
            S_EX1_DR:   w_state_nxt = tms ? S_UPD_DR   : S_PAUSE_DR;
            S_PAUSE_DR: w_state_nxt = tms ? S_EX2_DR   : S_PAUSE_DR;
            S_EX2_DR:   w_state_nxt = tms ? S_UPD_DR   : S_SH_DR;
            S_UPD_DR:   w_state_nxt = tms ? S_SEL_DR   : S_RTI;
            S_SEL_IR:   w_state_nxt = tms ? S_TLR      : S_CAP_IR;
            S_CAP_IR:   w_state_nxt = tms ? S_EX1_IR   : S_SH_IR;
            S_SH_IR:    w_state_nxt = tms ? S_EX1_IR   : S_SH_IR;
            S_EX1_IR:   w_state_nxt = tms ? S_UPD_IR   : S_PAUSE_IR;
            S_PAUSE_IR: w_state_nxt = tms ? S_EX2_IR   : S_PAUSE_IR;
            S_EX2_IR:   w_state_nxt = tms ? S_UPD_IR   : S_SH_IR;
            S_UPD_IR:   w_state_nxt = tms ? S_SEL_DR   : S_RTI;
            default:    w_state_nxt = S_TLR;
        endcase
    end

    // State decode: which register action the current state requests
    always_comb begin
        w_cap_dr = 1'b0;
        w_sh_dr  = 1'b0;
        w_upd_dr = 1'b0;
        w_cap_ir = 1'b0;
        w_sh_ir  = 1'b0;
        w_upd_ir = 1'b0;
        case (r_state)
            S_CAP_DR: w_cap_dr = 1'b1;
            S_SH_DR:  w_sh_dr  = 1'b1;
            S_UPD_DR: w_upd_dr = 1'b1;
            S_CAP_IR: w_cap_ir = 1'b1;
            S_SH_IR:  w_sh_ir  = 1'b1;
            S_UPD_IR: w_upd_ir = 1'b1;
            default:  w_cap_dr = 1'b0;
        endcase
    end

    // Instruction decode into a DR select; all-ones is checked first so it always means bypass
    always_comb begin
        w_sel_id   = 1'b0;
        w_sel_bsr  = 1'b0;
        w_sel_user = 1'b0;
        if (r_ir == INS_BYPASS) begin
            w_sel_id = 1'b0;
        end else if (r_ir == INS_IDCODE) begin
            w_sel_id = 1'b1;
        end else if ((r_ir == INS_EXTEST) || (r_ir == INS_SAMPLE)) begin
            w_sel_bsr = 1'b1;
        end else if (r_ir == INS_USER) begin
            w_sel_user = 1'b1;
        end else begin
            w_sel_id = 1'b0;
        end
    end

    // Serial output bit of whichever DR is selected
    always_comb begin
        w_dr_lsb = r_byp;
        if (w_sel_id) begin
            w_dr_lsb = r_id_sr[0];
        end else if (w_sel_bsr) begin
            w_dr_lsb = r_bsr_sr[0];
        end else if (w_sel_user) begin
            w_dr_lsb = r_user_sr[0];
        end else begin
            w_dr_lsb = r_byp;
        end
    end

    // Instruction shift register: capture 01 pattern, shift in Shift-IR
    always_ff @(posedge tclk or posedge trst) begin
        if (trst) begin
            r_ir_sr <= '0;
        end else if (w_cap_ir) begin
            r_ir_sr <= IR_CAPTURE;
        end else if (w_sh_ir) begin
            r_ir_sr <= w_ir_shift[IR_W:1];
        end else begin
            r_ir_sr <= r_ir_sr;
        end
    end

    // Active instruction: forced to IDCODE whenever TLR is entered or held
    always_ff @(posedge tclk or posedge trst) begin
        if (trst) begin
            r_ir <= INS_IDCODE;
        end else if (w_state_nxt == S_TLR) begin
            r_ir <= INS_IDCODE;
        end else if (w_upd_ir) begin
            r_ir <= r_ir_sr;
        end else begin
            r_ir <= r_ir;
        end
    end

    // IDCODE shift register
    always_ff @(posedge tclk or posedge trst) begin
        if (trst) begin
            r_id_sr <= '0;
        end else if (w_sel_id && w_cap_dr) begin
            r_id_sr <= IDCODE;
        end else if (w_sel_id && w_sh_dr) begin
            r_id_sr <= w_id_shift[32:1];
        end else begin
            r_id_sr <= r_id_sr;
        end
    end

    // Boundary-scan shift register: captures pad/core values
    always_ff @(posedge tclk or posedge trst) begin
        if (trst) begin
            r_bsr_sr <= '0;
        end else if (w_sel_bsr && w_cap_dr) begin
            r_bsr_sr <= pin_in;
        end else if (w_sel_bsr && w_sh_dr) begin
            r_bsr_sr <= w_bsr_shift[BSR_LEN:1];
        end else begin
            r_bsr_sr <= r_bsr_sr;
        end
    end

    // User shift register: captures the current user latch for read-back
    always_ff @(posedge tclk or posedge trst) begin
        if (trst) begin
            r_user_sr <= '0;
        end else if (w_sel_user && w_cap_dr) begin
            r_user_sr <= r_user_dr;
        end else if (w_sel_user && w_sh_dr) begin
            r_user_sr <= w_user_shift[USER_W:1];
        end else begin
            r_user_sr <= r_user_sr;
        end
    end

    // Bypass bit: captures 0 so the scan-out leads with a known value
    always_ff @(posedge tclk or posedge trst) begin
        if (trst) begin
            r_byp <= 1'b0;
        end else if (!w_sel_id && !w_sel_bsr && !w_sel_user && w_cap_dr) begin
            r_byp <= 1'b0;
        end else if (!w_sel_id && !w_sel_bsr && !w_sel_user && w_sh_dr) begin
            r_byp <= tdi;
        end else begin
            r_byp <= r_byp;
        end
    end

    // Boundary-scan update latches: only change in Update-DR
    always_ff @(posedge tclk or posedge trst) begin
        if (trst) begin
            r_pin_out <= '0;
        end else if (w_sel_bsr && w_upd_dr) begin
            r_pin_out <= r_bsr_sr;
        end else begin
            r_pin_out <= r_pin_out;
        end
    end

    // User update latch and its single-cycle strobe
    always_ff @(posedge tclk or posedge trst) begin
        if (trst) begin
            r_user_dr     <= '0;
            r_user_update <= 1'b0;
        end else if (w_sel_user && w_upd_dr) begin
            r_user_dr     <= r_user_sr;
            r_user_update <= 1'b1;
        end else begin
            r_user_dr     <= r_user_dr;
            r_user_update <= 1'b0;
        end
    end

    // TDO launch on the falling edge, half a cycle ahead of the next shift
    always_ff @(negedge tclk or posedge trst) begin
        if (trst) begin
            r_tdo    <= 1'b0;
            r_tdo_en <= 1'b0;
        end else if (w_sh_ir) begin
            r_tdo    <= r_ir_sr[0];
            r_tdo_en <= 1'b1;
        end else if (w_sh_dr) begin
            r_tdo    <= w_dr_lsb;
            r_tdo_en <= 1'b1;
        end else begin
            r_tdo    <= 1'b0;
            r_tdo_en <= 1'b0;
        end
    end

    assign tdo         = r_tdo;
    assign tdo_en      = r_tdo_en;
    assign pin_out     = r_pin_out;
    assign extest      = (r_ir == INS_EXTEST);
    assign user_dr     = r_user_dr;
    assign user_update = r_user_update;
    assign state       = r_state;
    assign ir          = r_ir;

endmodule

// File: tb/tb_jtag_tap_param.sv
// Scoreboard bench for jtag_tap_param: scan tasks push expected TDO bits,
// a negedge monitor pops and compares them whenever tdo_en is high.
module tb_jtag_tap_param;

    localparam int unsigned IR_W    = 4;
    localparam logic [31:0] IDC     = 32'h1000_563F;
    localparam int unsigned BSR_LEN = 8;
    localparam int unsigned USER_W  = 8;

    logic                tclk = 1'b0;
    logic                trst = 1'b1;
    logic                tms  = 1'b1;
    logic                tdi  = 1'b0;
    logic                tdo;
    logic                tdo_en;
    logic [BSR_LEN-1:0]  pin_in = '0;
    logic [BSR_LEN-1:0]  pin_out;
    logic                extest;
    logic [USER_W-1:0]   user_dr;
    logic                user_update;
    logic [3:0]          state;
    logic [IR_W-1:0]     ir;

    jtag_tap_param #(
        .IR_W(IR_W), .IDCODE(IDC), .BSR_LEN(BSR_LEN), .USER_W(USER_W)
    ) dut (
        .tclk(tclk), .trst(trst), .tms(tms), .tdi(tdi),
        .tdo(tdo), .tdo_en(tdo_en), .pin_in(pin_in), .pin_out(pin_out),
        .extest(extest), .user_dr(user_dr), .user_update(user_update),
        .state(state), .ir(ir)
    );

    always #5 tclk = ~tclk;

    int checks = 0;
    int errors = 0;
    bit exp_q[$];
    int upd_seen = 0;

    // Reference model: architectural view of the TAP
    logic [IR_W-1:0]    m_ir      = IR_W'(1);
    logic [USER_W-1:0]  m_user    = '0;
    logic [BSR_LEN-1:0] m_pin_out = '0;
    int                 m_upd     = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: samples just after each falling edge, when TDO has settled
    always begin
        @(negedge tclk);
        #1;
        if (!trst) begin
            if (user_update) upd_seen++;
            checks++;
            if (tdo_en) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL tdo_unexpected actual tdo_en=1 required tdo_en=0");
                end else begin
                    bit e;
                    e = exp_q.pop_front();
                    if (tdo !== e) begin
                        errors++;
                        $display("FAIL tdo_bit actual=%0b required=%0b", tdo, e);
                    end
                end
            end else if (tdo !== 1'b0) begin
                errors++;
                $display("FAIL tdo_idle actual=%0b required=0", tdo);
            end
        end
    end

    task automatic tck(input logic m, input logic d);
        @(negedge tclk);
        tms = m;
        tdi = d;
    endtask

    task automatic settle();
        @(negedge tclk);
        #2;
    endtask

    // 0 bypass, 1 idcode, 2 boundary scan, 3 user
    function automatic int kind_of(input logic [IR_W-1:0] c);
        if (c == {IR_W{1'b1}}) return 0;
        if (c == IR_W'(1)) return 1;
        if (c == IR_W'(0) || c == IR_W'(2)) return 2;
        if (c == IR_W'(3)) return 3;
        return 0;
    endfunction

    function automatic int len_of(input int k);
        case (k)
            1:       return 32;
            2:       return BSR_LEN;
            3:       return USER_W;
            default: return 1;
        endcase
    endfunction

    task automatic check_regs(input string tag);
        chk({tag, "_pin_out"}, 64'(pin_out), 64'(m_pin_out));
        chk({tag, "_user_dr"}, 64'(user_dr), 64'(m_user));
        chk({tag, "_upd_cnt"}, 64'(upd_seen), 64'(m_upd));
        chk({tag, "_extest"}, 64'(extest), 64'(m_ir == IR_W'(0)));
    endtask

    // IR scan from RTI back to RTI; shift-out is the capture pattern 1,0,0,...
    task automatic scan_ir(input logic [IR_W-1:0] v);
        for (int i = 0; i < int'(IR_W); i++) exp_q.push_back(i == 0);
        tck(1'b1, 1'b0); tck(1'b1, 1'b0); tck(1'b0, 1'b0); tck(1'b0, 1'b0);
        for (int i = 0; i < int'(IR_W); i++) tck(i == int'(IR_W) - 1, v[i]);
        tck(1'b1, 1'b0); tck(1'b0, 1'b0);
        m_ir = v;
        settle();
        chk("ir_after_scan", 64'(ir), 64'(m_ir));
        chk("state_rti_ir", 64'(state), 64'd1);
        check_regs("ir");
    endtask

    // DR scan of n bits; abort leaves Shift-DR with five tms=1 to reach TLR
    task automatic scan_dr(input logic [63:0] data, input int n, input bit abort);
        bit stream[$];
        logic [63:0] cap;
        logic [63:0] fin;
        int k, len;
        k   = kind_of(m_ir);
        len = len_of(k);
        case (k)
            1:       cap = 64'(IDC);
            2:       cap = 64'(pin_in);
            3:       cap = 64'(m_user);
            default: cap = 64'd0;
        endcase
        for (int i = 0; i < len; i++) stream.push_back(cap[i]);
        for (int i = 0; i < n; i++) stream.push_back(data[i]);
        for (int i = 0; i < n; i++) exp_q.push_back(stream[i]);
        fin = '0;
        for (int j = 0; j < len; j++) fin[j] = stream[n + j];
        tck(1'b1, 1'b0); tck(1'b0, 1'b0); tck(1'b0, 1'b0);
        for (int i = 0; i < n; i++) tck(i == n - 1, data[i]);
        // Exit1 -> Update happens on both paths
        tck(1'b1, 1'b0);
        if (k == 2) m_pin_out = fin[BSR_LEN-1:0];
        if (k == 3) begin
            m_user = fin[USER_W-1:0];
            m_upd++;
        end
        if (abort) begin
            tck(1'b1, 1'b0); tck(1'b1, 1'b0); tck(1'b1, 1'b0);
            m_ir = IR_W'(1);
            settle();
            chk("abort_state_tlr", 64'(state), 64'd0);
            chk("abort_ir_idcode", 64'(ir), 64'd1);
        end
        tck(1'b0, 1'b0);
        settle();
        chk("state_rti_dr", 64'(state), 64'd1);
        chk("ir_after_dr", 64'(ir), 64'(m_ir));
        check_regs("dr");
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_state"}, 64'(state), 64'd0);
        chk({tag, "_ir"}, 64'(ir), 64'd1);
        chk({tag, "_tdo"}, 64'(tdo), 64'd0);
        chk({tag, "_tdo_en"}, 64'(tdo_en), 64'd0);
        chk({tag, "_pin_out"}, 64'(pin_out), 64'd0);
        chk({tag, "_user_dr"}, 64'(user_dr), 64'd0);
        chk({tag, "_user_update"}, 64'(user_update), 64'd0);
        chk({tag, "_extest"}, 64'(extest), 64'd0);
    endtask

    initial begin
        #12;
        check_reset_outputs("reset");
        trst = 1'b0;
        tck(1'b1, 1'b0);
        settle();
        chk("tlr_hold_state", 64'(state), 64'd0);
        chk("tlr_hold_ir", 64'(ir), 64'd1);
        tck(1'b0, 1'b0);
        settle();
        chk("rti_state", 64'(state), 64'd1);

        // IDCODE read-out with tdi held at 0
        scan_dr(64'd0, 32, 1'b0);

        // Bypass: pattern 1,0,1,1 comes back one bit late behind a 0
        scan_ir({IR_W{1'b1}});
        scan_dr(64'b1101, 4, 1'b0);

        // SAMPLE: capture 0xA5, shift in 0x3C, update pins
        pin_in = 8'hA5;
        scan_ir(IR_W'(2));
        scan_dr(64'h3C, 8, 1'b0);
        chk("sample_pin_out", 64'(pin_out), 64'h3C);

        // USER write then read-back
        scan_ir(IR_W'(3));
        scan_dr(64'h5A, 8, 1'b0);
        chk("user_dr_5a", 64'(user_dr), 64'h5A);
        scan_dr({$urandom, $urandom}, 8, 1'b0);

        // Five tms=1 out of Shift-DR under bypass: back to TLR, no update
        scan_ir({IR_W{1'b1}});
        scan_dr({$urandom, $urandom}, 5, 1'b1);

        // Unassigned code behaves as bypass
        scan_ir(IR_W'(6));
        scan_dr({$urandom, $urandom}, 10, 1'b0);

        // Asynchronous reset in the middle of a USER shift
        scan_ir(IR_W'(3));
        for (int i = 0; i < 3; i++) exp_q.push_back(m_user[i]);
        tck(1'b1, 1'b0); tck(1'b0, 1'b0); tck(1'b0, 1'b0);
        tck(1'b0, 1'b1); tck(1'b0, 1'b0);
        @(negedge tclk);
        #3;
        trst = 1'b1;
        #1;
        check_reset_outputs("trst_mid");
        chk("trst_mid_upd_cnt", 64'(upd_seen), 64'(m_upd));
        chk("trst_mid_pending", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        m_ir = IR_W'(1);
        m_user = '0;
        m_pin_out = '0;
        #10;
        trst = 1'b0;
        tck(1'b0, 1'b0);
        settle();
        chk("post_trst_rti", 64'(state), 64'd1);
        check_regs("post_trst");

        // Randomized scans against the model
        for (int it = 0; it < 40; it++) begin
            int op;
            pin_in = BSR_LEN'($urandom);
            op = int'($urandom_range(0, 6));
            case (op)
                0, 1, 2, 3: scan_ir(IR_W'(op));
                4:          scan_ir({IR_W{1'b1}});
                5:          scan_ir(IR_W'($urandom));
                default:    ;
            endcase
            scan_dr({$urandom, $urandom}, int'($urandom_range(1, 40)),
                    $urandom_range(0, 5) == 0);
        end

        settle();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time guard so the run always ends
    initial begin
        #400000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
